// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core: sequences the shared datapath
// over several cycles per instruction, with a memory-ready handshake on every access.
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       InstrDone,
  output logic       IllegalOp
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BEQ, JAL, JALR1, JALR2
  } state_t;

  state_t state;
  state_t cur;
  logic   pc_update, branch, ir_write, mem_write, reg_write, done, illegal;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    if (MemReady) state <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= MEMADR;
            OP_R:         state <= EXECR;
            OP_I:         state <= EXECI;
            OP_BEQ:       state <= BEQ;
            OP_JAL:       state <= JAL;
            OP_JALR:      state <= JALR1;
            default:      state <= FETCH;
          endcase
        end
        MEMADR:   state <= (op == OP_LW) ? MEMREAD : MEMWRITE;
        MEMREAD:  if (MemReady) state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: if (MemReady) state <= FETCH;
        EXECR:    state <= ALUWB;
        EXECI:    state <= ALUWB;
        ALUWB:    state <= FETCH;
        BEQ:      state <= FETCH;
        JAL:      state <= ALUWB;
        JALR1:    state <= JALR2;
        JALR2:    state <= ALUWB;
        default:  state <= FETCH;
      endcase
    end
  end

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // While reset is held the decode behaves as FETCH, and every strobe is masked below.
  always_comb begin
    cur       = reset ? FETCH : state;
    pc_update = 1'b0;
    branch    = 1'b0;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    case (cur)
      FETCH: begin
        ir_write  = MemReady;
        pc_update = MemReady;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        if (!(op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, OP_JALR})) begin
          illegal = 1'b1;
          done    = 1'b1;
        end
      end
      MEMADR, JALR1: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        reg_write = 1'b1;
        done      = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        done      = MemReady;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      ALUWB: begin
        reg_write = 1'b1;
        done      = 1'b1;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        branch  = 1'b1;
        done    = 1'b1;
      end
      JAL, JALR2: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
    PCWrite   = !reset && (pc_update || (branch && Zero));
    IRWrite   = !reset && ir_write;
    MemWrite  = !reset && mem_write;
    RegWrite  = !reset && reg_write;
    InstrDone = !reset && done;
    IllegalOp = !reset && illegal;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed table-driven bench for multicycle_ctrl: each row drives one cycle of
// inputs and checks the full control word before the next rising edge.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'b0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, InstrDone, IllegalOp;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .InstrDone(InstrDone), .IllegalOp(IllegalOp)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111,
                         JR = 7'b1100111, IL = 7'b0000000;

  // Control word: {PCWrite,AdrSrc,MemWrite,IRWrite}_ResultSrc_ALUSrcA_ALUSrcB_ALUOp_ImmSrc_{RegWrite,InstrDone,IllegalOp}
  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        zero;
    logic        rdy;
    logic [16:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic void add(logic rst, logic [6:0] o, logic z, logic r, logic [16:0] e, string nm);
    vec_t v;
    v.rst = rst; v.op = o; v.zero = z; v.rdy = r; v.exp = e; v.name = nm;
    vecs.push_back(v);
  endfunction

  task automatic apply(vec_t v);
    logic [16:0] act;
    @(negedge clk);
    reset = v.rst; op = v.op; Zero = v.zero; MemReady = v.rdy;
    #2;
    act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUOp, ImmSrc, RegWrite, InstrDone, IllegalOp};
    n_checks++;
    if (act !== v.exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", v.name, act, v.exp);
    end
    n_checks++;
    if (RegWrite && MemWrite) begin
      n_fail++;
      $display("FAIL %s_excl: RegWrite=%b MemWrite=%b, required not both 1", v.name, RegWrite, MemWrite);
    end
  endtask

  task automatic step(logic rst, logic [6:0] o, logic z, logic r, logic [16:0] e, string nm);
    vec_t v;
    v.rst = rst; v.op = o; v.zero = z; v.rdy = r; v.exp = e; v.name = nm;
    apply(v);
  endtask

  initial begin
    // reset from power-up
    add(1, RT, 0, 1, 17'b0000_10_00_10_00_00_000, "reset0");
    add(1, RT, 0, 1, 17'b0000_10_00_10_00_00_000, "reset1");
    // R-type, MemReady low outside FETCH must not matter
    add(0, RT, 0, 1, 17'b1001_10_00_10_00_00_000, "r_fetch");
    add(0, RT, 0, 0, 17'b0000_00_01_01_00_00_000, "r_decode");
    add(0, RT, 0, 0, 17'b0000_00_10_00_10_00_000, "r_execr");
    add(0, RT, 0, 0, 17'b0000_00_00_00_00_00_110, "r_aluwb");
    // lw with 2 fetch waits and 3 memory waits: 10 cycles
    add(0, LW, 0, 0, 17'b0000_10_00_10_00_00_000, "lw_fwait0");
    add(0, LW, 0, 0, 17'b0000_10_00_10_00_00_000, "lw_fwait1");
    add(0, LW, 0, 1, 17'b1001_10_00_10_00_00_000, "lw_fetch");
    add(0, LW, 0, 0, 17'b0000_00_01_01_00_00_000, "lw_decode");
    add(0, LW, 0, 1, 17'b0000_00_10_01_00_00_000, "lw_memadr");
    add(0, LW, 0, 0, 17'b0100_00_00_00_00_00_000, "lw_mwait0");
    add(0, LW, 0, 0, 17'b0100_00_00_00_00_00_000, "lw_mwait1");
    add(0, LW, 0, 0, 17'b0100_00_00_00_00_00_000, "lw_mwait2");
    add(0, LW, 0, 1, 17'b0100_00_00_00_00_00_000, "lw_memread");
    add(0, LW, 0, 0, 17'b0000_01_00_00_00_00_110, "lw_memwb");
    // sw with two write-wait cycles
    add(0, SW, 0, 1, 17'b1001_10_00_10_00_01_000, "sw_fetch");
    add(0, SW, 0, 1, 17'b0000_00_01_01_00_01_000, "sw_decode");
    add(0, SW, 0, 0, 17'b0000_00_10_01_00_01_000, "sw_memadr");
    add(0, SW, 0, 0, 17'b0110_00_00_00_00_01_000, "sw_mwait0");
    add(0, SW, 0, 0, 17'b0110_00_00_00_00_01_000, "sw_mwait1");
    add(0, SW, 0, 1, 17'b0110_00_00_00_00_01_010, "sw_memwrite");
    // beq taken, then not taken
    add(0, BQ, 1, 1, 17'b1001_10_00_10_00_10_000, "beq1_fetch");
    add(0, BQ, 1, 1, 17'b0000_00_01_01_00_10_000, "beq1_decode");
    add(0, BQ, 1, 1, 17'b1000_00_10_00_01_10_010, "beq1_taken");
    add(0, BQ, 0, 1, 17'b1001_10_00_10_00_10_000, "beq0_fetch");
    add(0, BQ, 0, 1, 17'b0000_00_01_01_00_10_000, "beq0_decode");
    add(0, BQ, 0, 1, 17'b0000_00_10_00_01_10_010, "beq0_nottaken");
    // jal
    add(0, JL, 0, 1, 17'b1001_10_00_10_00_11_000, "jal_fetch");
    add(0, JL, 0, 1, 17'b0000_00_01_01_00_11_000, "jal_decode");
    add(0, JL, 0, 1, 17'b1000_00_01_10_00_11_000, "jal_jal");
    add(0, JL, 0, 1, 17'b0000_00_00_00_00_11_110, "jal_aluwb");
    // jalr
    add(0, JR, 0, 1, 17'b1001_10_00_10_00_00_000, "jalr_fetch");
    add(0, JR, 0, 1, 17'b0000_00_01_01_00_00_000, "jalr_decode");
    add(0, JR, 0, 1, 17'b0000_00_10_01_00_00_000, "jalr_jalr1");
    add(0, JR, 0, 1, 17'b1000_00_01_10_00_00_000, "jalr_jalr2");
    add(0, JR, 0, 1, 17'b0000_00_00_00_00_00_110, "jalr_aluwb");
    // I-type
    add(0, IT, 0, 1, 17'b1001_10_00_10_00_00_000, "i_fetch");
    add(0, IT, 0, 1, 17'b0000_00_01_01_00_00_000, "i_decode");
    add(0, IT, 0, 1, 17'b0000_00_10_01_10_00_000, "i_execi");
    add(0, IT, 0, 1, 17'b0000_00_00_00_00_00_110, "i_aluwb");
    // illegal opcode returns straight to FETCH
    add(0, IL, 0, 1, 17'b1001_10_00_10_00_00_000, "ill_fetch");
    add(0, IL, 0, 1, 17'b0000_00_01_01_00_00_011, "ill_decode");
    add(0, IL, 0, 0, 17'b0000_10_00_10_00_00_000, "ill_back_fetch");

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Reset mid-store: no write strobe during reset, then a clean fetch
    step(0, SW, 0, 1, 17'b1001_10_00_10_00_01_000, "rsw_fetch");
    step(0, SW, 0, 1, 17'b0000_00_01_01_00_01_000, "rsw_decode");
    step(0, SW, 0, 1, 17'b0000_00_10_01_00_01_000, "rsw_memadr");
    step(0, SW, 0, 0, 17'b0110_00_00_00_00_01_000, "rsw_mwait");
    step(1, SW, 0, 1, 17'b0000_10_00_10_00_01_000, "rsw_reset0");
    step(1, SW, 0, 1, 17'b0000_10_00_10_00_01_000, "rsw_reset1");
    step(0, SW, 0, 1, 17'b1001_10_00_10_00_01_000, "rsw_refetch");
    step(0, SW, 0, 1, 17'b0000_00_01_01_00_01_000, "rsw_redecode");

    // Reset in MEMWB of a load: RegWrite and InstrDone suppressed
    step(0, LW, 0, 1, 17'b0000_00_10_01_00_00_000, "rlw_memadr");
    step(0, LW, 0, 1, 17'b0100_00_00_00_00_00_000, "rlw_memread");
    step(1, LW, 0, 1, 17'b0000_10_00_10_00_00_000, "rlw_reset_in_wb");
    step(1, BQ, 1, 1, 17'b0000_10_00_10_00_10_000, "rlw_reset_hold");
    step(0, BQ, 1, 0, 17'b0000_10_00_10_00_10_000, "rlw_fetch_wait");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
